stage_controller: RTL and testbench

STAGE_CONTROLLER -- requirements
Module: stage_controller

---
 rtl/stage_controller.sv | 103 ++++++++++
 tb/tb_stage_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_controller.sv
// Multi-cycle stage sequencer: FETCH, REG_READ, EXECUTE, MEMORY, WRITEBACK, with a terminal HALTED state.
// Five cycles per instruction at minimum; FETCH and MEMORY (for loads/stores) stall while mem_ready is low.
module stage_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [4:0]  INSTR_LOAD  = 5'd1,
  parameter logic [4:0]  INSTR_STORE = 5'd2,
  parameter logic [4:0]  INSTR_HALT  = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ready,
  input  logic [31:0] mem_read_data,
  input  logic [4:0]  current_instr_type,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [2:0]  stage,
  output logic [31:0] PC_value,
  output logic [31:0] instr_reg,
  output logic        instr_retired,
  output logic        halted
);

  typedef enum logic [2:0] {
    INSTR_FETCH = 3'd0,
    REG_READ    = 3'd1,
    EXECUTE     = 3'd2,
    MEMORY      = 3'd3,
    WRITEBACK   = 3'd4,
    HALTED      = 3'd5
  } stage_e;

  stage_e      stage_q, stage_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        retired_q, retired_d;
  logic        is_mem_op;
  logic [31:0] pc_next;
  logic        unused_target_bits;

  // Branch targets are forced word-aligned, so the low bits are never consumed.
  assign unused_target_bits = ^branch_target[1:0];

  assign is_mem_op = (current_instr_type == INSTR_LOAD) ||
                     (current_instr_type == INSTR_STORE);
  assign pc_next   = branch_taken ? {branch_target[31:2], 2'b00} : (pc_q + 32'd4);

  always_comb begin
    stage_d   = stage_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = 1'b0;
    case (stage_q)
      INSTR_FETCH: begin
        if (mem_ready) begin
          instr_d = mem_read_data;
          stage_d = REG_READ;
        end
      end
      REG_READ: stage_d = EXECUTE;
      EXECUTE: begin
        if (current_instr_type == INSTR_HALT) begin
          stage_d = HALTED;
        end else begin
          stage_d = MEMORY;
        end
      end
      MEMORY: begin
        if (!is_mem_op || mem_ready) begin
          stage_d = WRITEBACK;
        end
      end
      WRITEBACK: begin
        pc_d      = pc_next;
        retired_d = 1'b1;
        stage_d   = INSTR_FETCH;
      end
      HALTED: stage_d = HALTED;
      // Encodings 6/7 are unreachable but recover to fetch without touching the PC.
      default: stage_d = INSTR_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q   <= INSTR_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      retired_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign stage         = stage_q;
  assign PC_value      = pc_q;
  assign instr_reg     = instr_q;
  assign instr_retired = retired_q;
  assign halted        = (stage_q == HALTED);

endmodule

// File: tb/tb_stage_controller.sv
// Directed bench for stage_controller; a monitor scores every retire pulse against a queue of expected results.
module tb_stage_controller;
  localparam logic [4:0] T_ALU   = 5'd4;
  localparam logic [4:0] T_LOAD  = 5'd1;
  localparam logic [4:0] T_STORE = 5'd2;
  localparam logic [4:0] T_HALT  = 5'd31;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_read_data = 32'd0;
  logic [4:0]  current_instr_type = 5'd0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [2:0]  stage;
  logic [31:0] PC_value;
  logic [31:0] instr_reg;
  logic        instr_retired;
  logic        halted;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;

  stage_controller #(
    .RESET_PC(32'h0000_0040), .INSTR_LOAD(T_LOAD), .INSTR_STORE(T_STORE), .INSTR_HALT(T_HALT)
  ) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .mem_read_data(mem_read_data),
    .current_instr_type(current_instr_type), .branch_taken(branch_taken),
    .branch_target(branch_target), .stage(stage), .PC_value(PC_value),
    .instr_reg(instr_reg), .instr_retired(instr_retired), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: counts cycles per instruction and scores each retire pulse.
  always @(negedge clk) begin
    if (rst) begin
      cyc_cnt = 0;
    end else if (instr_retired) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_retire actual=pulse expected=none pc=%h", PC_value);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("retire_pc", PC_value, e.pc);
        chk("retire_instr", instr_reg, e.instr);
        chk("retire_latency", cyc_cnt, e.lat);
      end
      cyc_cnt = 1;
    end else begin
      cyc_cnt++;
    end
  end

  // Called at posedge+1 with the DUT in INSTR_FETCH; plays memory and branch unit for one instruction.
  task automatic run_instr(input logic [31:0] word, input logic [4:0] typ, input int fstall,
                           input int mstall, input logic br, input logic [31:0] tgt,
                           input logic [31:0] pc_next);
    exp_t e;
    bit   is_mem;
    is_mem = (typ == T_LOAD) || (typ == T_STORE);
    if (typ != T_HALT) begin
      e.instr = word;
      e.pc    = pc_next;
      e.lat   = 5 + fstall + (is_mem ? mstall : 0);
      exp_q.push_back(e);
    end
    current_instr_type = typ;
    branch_taken  = ~br;
    branch_target = 32'hBAD0_0008;
    mem_ready     = 1'b0;
    mem_read_data = 32'h0BAD_F00D;
    for (int i = 0; i < fstall; i++) begin
      chk("fetch_hold", stage, 0);
      @(posedge clk); #1;
    end
    chk("fetch", stage, 0);
    mem_ready     = 1'b1;
    mem_read_data = word;
    @(posedge clk); #1;
    chk("reg_read", stage, 1);
    mem_ready     = 1'b0;
    mem_read_data = 32'h0BAD_F00D;
    @(posedge clk); #1;
    chk("execute", stage, 2);
    @(posedge clk); #1;
    if (typ == T_HALT) begin
      chk("halt_stage", stage, 5);
      chk("halted_flag", halted, 1);
      return;
    end
    chk("memory", stage, 3);
    if (is_mem) begin
      for (int i = 0; i < mstall; i++) begin
        mem_ready = 1'b0;
        @(posedge clk); #1;
        chk("memory_hold", stage, 3);
      end
      mem_ready = 1'b1;
    end else begin
      mem_ready = (mstall == 0);
    end
    @(posedge clk); #1;
    chk("writeback", stage, 4);
    branch_taken  = br;
    branch_target = tgt;
    @(posedge clk); #1;
    chk("next_fetch", stage, 0);
    branch_taken = 1'b0;
    mem_ready    = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_pc"}, PC_value, 32'h0000_0040);
    chk({tag, "_instr"}, instr_reg, 0);
    chk({tag, "_retired"}, instr_retired, 0);
    chk({tag, "_halted"}, halted, 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 chk_reset_state("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Redirect to 0, then straight-line ALU code.
    run_instr(32'h1111_0000, T_ALU, 0, 0, 1'b1, 32'h0000_0000, 32'h0000_0000);
    run_instr(32'h2222_0001, T_ALU, 0, 0, 1'b0, 32'h0,        32'h0000_0004);
    run_instr(32'h2222_0002, T_ALU, 0, 0, 1'b0, 32'h0,        32'h0000_0008);
    run_instr(32'h2222_0003, T_ALU, 0, 0, 1'b0, 32'h0,        32'h0000_000C);
    // Fetch stall, memory stalls, non-memory op ignoring mem_ready.
    run_instr(32'hDEAD_BEEF, T_ALU,   3, 0, 1'b0, 32'h0, 32'h0000_0010);
    run_instr(32'h3333_0001, T_LOAD,  0, 2, 1'b0, 32'h0, 32'h0000_0014);
    run_instr(32'h3333_0002, T_ALU,   0, 1, 1'b0, 32'h0, 32'h0000_0018);
    run_instr(32'h3333_0003, T_STORE, 0, 1, 1'b0, 32'h0, 32'h0000_001C);
    // Branch alignment and PC wrap.
    run_instr(32'h4444_0001, T_ALU, 0, 0, 1'b1, 32'h0000_0103, 32'h0000_0100);
    run_instr(32'h4444_0002, T_ALU, 0, 0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC);
    run_instr(32'h4444_0003, T_ALU, 0, 0, 1'b0, 32'h0,         32'h0000_0000);

    // Halt freezes everything with no retire pulse.
    run_instr(32'hF000_0000, T_HALT, 0, 0, 1'b0, 32'h0, 32'h0);
    mem_ready     = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0800;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("frozen_stage", stage, 5);
      chk("frozen_pc", PC_value, 32'h0000_0000);
      chk("frozen_instr", instr_reg, 32'hF000_0000);
      chk("frozen_retired", instr_retired, 0);
    end
    branch_taken = 1'b0;
    rst = 1'b1;
    #1 chk_reset_state("halt_reset");
    @(posedge clk); #1 rst = 1'b0;

    // Asynchronous reset in the middle of a load's memory wait.
    run_instr(32'h5555_0001, T_ALU, 0, 0, 1'b0, 32'h0, 32'h0000_0044);
    current_instr_type = T_LOAD;
    mem_ready     = 1'b1;
    mem_read_data = 32'h1234_5678;
    @(posedge clk); #1;
    chk("abort_reg_read", stage, 1);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_memory", stage, 3);
    @(posedge clk); #1;
    chk("abort_memory_hold", stage, 3);
    chk("abort_instr_latched", instr_reg, 32'h1234_5678);
    #2 rst = 1'b1;
    #1 chk_reset_state("async_reset");
    @(posedge clk); #1 rst = 1'b0;
    run_instr(32'h6666_0001, T_ALU, 0, 0, 1'b0, 32'h0, 32'h0000_0044);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
